psram_apb_wb_bridge: RTL and testbench

- APB3/APB4 slave to Wishbone classic master bridge, sitting directly upstream of the PSRAM Wishbone controller in the APB peripheral tree.
- Converts each APB transfer into exactly one Wishbone cycle.
- Screens byte-strobe patterns the controller cannot execute.
- Holds cyc/stb/we stable for the whole cycle and drops them the cycle after ack, so the controller never sees a spurious back-to-back request.

---
 rtl/psram_apb_wb_bridge.sv | 201 ++++++++++++++++++++
 tb/tb_psram_apb_wb_bridge.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/psram_apb_wb_bridge.sv
// APB3/APB4 slave to Wishbone classic master bridge in front of the PSRAM controller.
// Optional posted writes are enabled by defining PSRAM_BRIDGE_POSTED_WRITE_EN.
module psram_apb_wb_bridge #(
  parameter int ADDR_WIDTH = 24
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic [3:0]  sel_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  input  logic        ack_i
);

`ifdef PSRAM_BRIDGE_POSTED_WRITE_EN
  localparam logic POSTED = 1'b1;
`else
  localparam logic POSTED = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, WB_BUSY = 2'd1, RESP = 2'd2} state_e;

  function automatic logic strb_legal(input logic [3:0] s);
    case (s)
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111: strb_legal = 1'b1;
      default: strb_legal = 1'b0;
    endcase
  endfunction

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d, qadr_q, qadr_d;
  logic [31:0]           dat_q, dat_d, qdat_q, qdat_d, prdata_q, prdata_d;
  logic [3:0]            sel_q, sel_d, qstrb_q, qstrb_d;
  logic                  we_q, we_d, cyc_q, cyc_d, pready_q, pready_d, pslverr_q, pslverr_d;
  logic                  pend_q, pend_d, qv_q, qv_d, qwr_q, qwr_d;

  // A queued transfer (posted mode only) takes precedence over the live APB bus in IDLE.
  logic                  setup_s, start_s, src_wr_s, launch_s, ack_s;
  logic [ADDR_WIDTH-1:0] src_adr_s;
  logic [31:0]           src_dat_s;
  logic [3:0]            src_strb_s;
  logic                  unused_paddr_s;

  assign setup_s        = psel & ~penable;
  assign start_s        = qv_q | setup_s;
  assign src_wr_s       = qv_q ? qwr_q : pwrite;
  assign src_adr_s      = qv_q ? qadr_q : paddr[ADDR_WIDTH-1:0];
  assign src_dat_s      = qv_q ? qdat_q : pwdata;
  assign src_strb_s     = qv_q ? qstrb_q : pstrb;
  assign launch_s       = ~src_wr_s | strb_legal(src_strb_s);
  assign ack_s          = ack_i & cyc_q;
  assign unused_paddr_s = &{1'b0, paddr[31:ADDR_WIDTH]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d = launch_s ? WB_BUSY : RESP;
        end else begin
          state_d = IDLE;
        end
      end
      WB_BUSY: begin
        if (ack_s) begin
          state_d = pend_q ? IDLE : RESP;
        end else begin
          state_d = WB_BUSY;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    pend_d    = pend_q;
    qv_d      = qv_q;
    qadr_d    = qadr_q;
    qdat_d    = qdat_q;
    qstrb_d   = qstrb_q;
    qwr_d     = qwr_q;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          adr_d = src_adr_s;
          dat_d = src_dat_s;
          qv_d  = 1'b0;
          if (launch_s) begin
            cyc_d    = 1'b1;
            we_d     = src_wr_s;
            sel_d    = src_wr_s ? src_strb_s : 4'b1111;
            pend_d   = POSTED & src_wr_s;
            pready_d = POSTED & src_wr_s;
          end else begin
            pready_d  = 1'b1;
            pslverr_d = (src_strb_s != 4'b0000);
          end
        end else begin
          qv_d = 1'b0;
        end
      end
      WB_BUSY: begin
        // While a posted write drains, hold the next setup phase until its ack.
        if (pend_q && !qv_q && setup_s) begin
          qv_d    = 1'b1;
          qadr_d  = paddr[ADDR_WIDTH-1:0];
          qdat_d  = pwdata;
          qstrb_d = pstrb;
          qwr_d   = pwrite;
        end else begin
          qv_d = qv_q;
        end
        if (ack_s) begin
          cyc_d    = 1'b0;
          we_d     = 1'b0;
          prdata_d = we_q ? prdata_q : dat_i;
          pready_d = ~pend_q;
          pend_d   = 1'b0;
        end else begin
          cyc_d = cyc_q;
        end
      end
      RESP:    pready_d = 1'b0;
      default: pready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      adr_q     <= '0;
      dat_q     <= 32'h0000_0000;
      sel_q     <= 4'b0000;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      prdata_q  <= 32'h0000_0000;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      pend_q    <= 1'b0;
      qv_q      <= 1'b0;
      qadr_q    <= '0;
      qdat_q    <= 32'h0000_0000;
      qstrb_q   <= 4'b0000;
      qwr_q     <= 1'b0;
    end else begin
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      cyc_q     <= cyc_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      pend_q    <= pend_d;
      qv_q      <= qv_d;
      qadr_q    <= qadr_d;
      qdat_q    <= qdat_d;
      qstrb_q   <= qstrb_d;
      qwr_q     <= qwr_d;
    end
  end

  assign adr_o   = {{(32 - ADDR_WIDTH){1'b0}}, adr_q};
  assign dat_o   = dat_q;
  assign sel_o   = sel_q;
  assign we_o    = we_q;
  assign cyc_o   = cyc_q;
  assign stb_o   = cyc_q;
  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_psram_apb_wb_bridge.sv
// Directed, table-driven bench for psram_apb_wb_bridge plus hand-written reset and posted-write sequences.
module tb_psram_apb_wb_bridge;
  logic        clk_i = 1'b0;
  logic        rst_i, psel, penable, pwrite, ack_i;
  logic [31:0] paddr, pwdata, dat_i, prdata, adr_o, dat_o;
  logic [3:0]  pstrb, sel_o;
  logic        pready, pslverr, cyc_o, stb_o, we_o;

  int checks = 0;
  int failures = 0;
  int cur_idx = -1;

  psram_apb_wb_bridge #(.ADDR_WIDTH(24)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .sel_o(sel_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .ack_i(ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          dly;
    logic [31:0] rdata;
    logic        exp_wb;
    logic [31:0] exp_adr;
    logic [3:0]  exp_sel;
    logic        exp_err;
    logic [31:0] exp_prdata;
  } vec_t;

  vec_t vecs[10];

  // results of the last transfer
  logic        r_ok, r_stable, r_stb_ok, r_cyc_at_ready, r_cyc_at_setup, r_err, r_we;
  logic [31:0] r_adr, r_dat, r_prdata;
  logic [3:0]  r_sel;
  int          r_cyc, r_lat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s idx=%0d got=%h expected=%h", nm, cur_idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Setup phase in the current cycle, access phase after, simple WB responder acking dly cycles after cyc_o.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int dly, input logic [31:0] rd);
    r_cyc_at_setup = cyc_o;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    tick();
    penable = 1'b1;
    r_ok = 1'b0; r_cyc = 0; r_stable = 1'b1; r_stb_ok = 1'b1; r_lat = -1;
    r_adr = 32'h0; r_dat = 32'h0; r_sel = 4'h0; r_we = 1'b0;
    r_prdata = 32'h0; r_err = 1'b0; r_cyc_at_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      ack_i = 1'b0;
      if (stb_o !== cyc_o) r_stb_ok = 1'b0;
      if (pready) begin
        r_ok = 1'b1; r_lat = c; r_prdata = prdata; r_err = pslverr; r_cyc_at_ready = cyc_o;
        break;
      end
      if (cyc_o) begin
        if (r_cyc == 0) begin
          r_adr = adr_o; r_sel = sel_o; r_we = we_o; r_dat = dat_o;
        end else if (adr_o !== r_adr || sel_o !== r_sel || we_o !== r_we || dat_o !== r_dat) begin
          r_stable = 1'b0;
        end
        if (r_cyc == dly) begin
          ack_i = 1'b1; dat_i = rd;
        end
        r_cyc++;
      end
      tick();
    end
    ack_i = 1'b0; psel = 1'b0; penable = 1'b0;
    tick();
  endtask

  task automatic chk_read_result(input logic [31:0] exp_adr, input logic [31:0] exp_rd, input int dly);
    chk("done", r_ok, 1);
    chk("latency", r_lat, dly + 1);
    chk("adr", r_adr, exp_adr);
    chk("sel", r_sel, 4'b1111);
    chk("we", r_we, 1'b0);
    chk("prdata", r_prdata, exp_rd);
    chk("cyc_at_ready", r_cyc_at_ready, 1'b0);
  endtask

  logic flag;

  initial begin
    rst_i = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0;
    pwdata = 32'h0; pstrb = 4'h0; dat_i = 32'h0; ack_i = 1'b0;
    vecs[0] = '{1'b0, 32'h8000_0104, 32'h0, 4'b0000, 20, 32'hDEAD_BEEF, 1'b1, 32'h0000_0104, 4'b1111, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h0000_0200, 32'h1122_3344, 4'b1100, 3, 32'h0, 1'b1, 32'h0000_0200, 4'b1100, 1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h0000_0300, 32'h5555_6666, 4'b0101, 2, 32'h0, 1'b0, 32'h0, 4'b0000, 1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 32'h0000_0304, 32'h7777_8888, 4'b0000, 2, 32'h0, 1'b0, 32'h0, 4'b0000, 1'b0, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 32'h12FF_FFFC, 32'h0, 4'b1010, 0, 32'hCAFE_F00D, 1'b1, 32'h00FF_FFFC, 4'b1111, 1'b0, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 32'hFF00_0010, 32'hA1B2_C3D4, 4'b0001, 1, 32'h0, 1'b1, 32'h0000_0010, 4'b0001, 1'b0, 32'hCAFE_F00D};
    vecs[6] = '{1'b1, 32'h0000_0020, 32'h0BAD_F00D, 4'b1111, 2, 32'h0, 1'b1, 32'h0000_0020, 4'b1111, 1'b0, 32'hCAFE_F00D};
    vecs[7] = '{1'b1, 32'h0000_0024, 32'h1357_2468, 4'b0110, 2, 32'h0, 1'b0, 32'h0, 4'b0000, 1'b1, 32'hCAFE_F00D};
    vecs[8] = '{1'b0, 32'h0000_0028, 32'h0, 4'b0000, 5, 32'h5A5A_A5A5, 1'b1, 32'h0000_0028, 4'b1111, 1'b0, 32'h5A5A_A5A5};
    vecs[9] = '{1'b1, 32'h0000_0FF0, 32'hFEED_FACE, 4'b0010, 4, 32'h0, 1'b1, 32'h0000_0FF0, 4'b0010, 1'b0, 32'h5A5A_A5A5};

    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    chk("reset_state", {prdata, adr_o[7:0], dat_o[7:0], sel_o, cyc_o, stb_o, we_o, pready, pslverr},
        {32'h0, 8'h0, 8'h0, 4'h0, 5'b00000});

    // penable without a setup phase must be ignored
    flag = 1'b0;
    psel = 1'b1; penable = 1'b1;
    repeat (4) begin
      if (pready || cyc_o) flag = 1'b1;
      tick();
    end
    psel = 1'b0; penable = 1'b0;
    chk("orphan_penable", flag, 1'b0);
    tick();

`ifndef PSRAM_BRIDGE_POSTED_WRITE_EN
    // vectors run back to back, each setup issued the cycle after the previous pready
    for (int i = 0; i < 10; i++) begin
      cur_idx = i;
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].dly, vecs[i].rdata);
      chk("done", r_ok, 1'b1);
      chk("latency", r_lat, vecs[i].exp_wb ? vecs[i].dly + 1 : 0);
      chk("cyc_cycles", r_cyc, vecs[i].exp_wb ? vecs[i].dly + 1 : 0);
      chk("pslverr", r_err, vecs[i].exp_err);
      chk("prdata", r_prdata, vecs[i].exp_prdata);
      chk("cyc_at_ready", r_cyc_at_ready, 1'b0);
      chk("cyc_at_setup", r_cyc_at_setup, 1'b0);
      chk("stb_eq_cyc", r_stb_ok, 1'b1);
      if (vecs[i].exp_wb) begin
        chk("adr", r_adr, vecs[i].exp_adr);
        chk("sel", r_sel, vecs[i].exp_sel);
        chk("we", r_we, vecs[i].wr);
        chk("held_stable", r_stable, 1'b1);
        if (vecs[i].wr) chk("dat", r_dat, vecs[i].wdata);
      end
    end
`else
    // posted write then read: write pready with cyc rising, read waits for the write's ack
    cur_idx = 100;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0000_0040;
    pwdata = 32'hAABB_CCDD; pstrb = 4'b1111;
    tick();
    penable = 1'b1;
    chk("posted_pready", {pready, pslverr, cyc_o, we_o}, {1'b1, 1'b0, 1'b1, 1'b1});
    tick();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_0044;
    chk("posted_hold", {pready, cyc_o, we_o}, {1'b0, 1'b1, 1'b1});
    tick();
    penable = 1'b1;
    chk("queued_wait", {pready, cyc_o, we_o, adr_o}, {1'b0, 1'b1, 1'b1, 32'h0000_0040});
    tick();
    chk("queued_wait2", {pready, cyc_o, we_o}, {1'b0, 1'b1, 1'b1});
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    chk("gap_after_ack", {pready, cyc_o}, {1'b0, 1'b0});
    tick();
    chk("read_start", {pready, cyc_o, we_o, sel_o, adr_o}, {1'b0, 1'b1, 1'b0, 4'b1111, 32'h0000_0044});
    ack_i = 1'b1; dat_i = 32'h1357_9BDF;
    tick();
    ack_i = 1'b0;
    chk("read_resp", {pready, pslverr, cyc_o, prdata}, {1'b1, 1'b0, 1'b0, 32'h1357_9BDF});
    psel = 1'b0; penable = 1'b0;
    tick();
`endif

    // reset 5 cycles into WB_BUSY, then stray ack, then a normal read
    cur_idx = 200;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_0100;
    tick();
    penable = 1'b1;
    repeat (5) tick();
    chk("busy_before_reset", cyc_o, 1'b1);
    rst_i = 1'b1; psel = 1'b0; penable = 1'b0;
    tick();
    rst_i = 1'b0;
    chk("reset_abort", {cyc_o, stb_o, pready}, {1'b0, 1'b0, 1'b0});
    ack_i = 1'b1; dat_i = 32'hBAAD_BAAD;
    tick();
    ack_i = 1'b0;
    flag = 1'b0;
    repeat (3) begin
      if (pready || cyc_o) flag = 1'b1;
      tick();
    end
    chk("stray_ack_ignored", {flag, prdata}, {1'b0, 32'h0});
    xfer(1'b0, 32'hC000_0500, 32'h0, 4'h0, 2, 32'h0F0F_1234);
    chk_read_result(32'h0000_0500, 32'h0F0F_1234, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
